// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port main-memory line arbiter.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 128;

  typedef enum logic [1:0] {
    ArbIdle,
    ArbBusyI,
    ArbBusyD,
    ArbAck
  } arb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              rw;
    logic [LINE_W-1:0] wdata;
    logic              valid;
  } line_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the icache/dcache engines, the arbiter and main memory.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = mem_arbiter_pkg::ADDR_W,
  parameter int unsigned LINE_W = mem_arbiter_pkg::LINE_W
);

  logic              ic_req_valid_i;
  logic [ADDR_W-1:0] ic_req_addr_i;
  logic              ic_ack_o;
  logic [LINE_W-1:0] ic_rdata_o;

  logic              dc_req_valid_i;
  logic              dc_req_rw_i;
  logic [ADDR_W-1:0] dc_req_addr_i;
  logic [LINE_W-1:0] dc_req_wdata_i;
  logic              dc_ack_o;
  logic [LINE_W-1:0] dc_rdata_o;

  logic              mem_valid_o;
  logic              mem_rw_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_wdata_o;
  logic              mem_ready_i;
  logic [LINE_W-1:0] mem_rdata_i;

  modport slave (
    input  ic_req_valid_i, ic_req_addr_i,
    output ic_ack_o, ic_rdata_o,
    input  dc_req_valid_i, dc_req_rw_i, dc_req_addr_i, dc_req_wdata_i,
    output dc_ack_o, dc_rdata_o,
    output mem_valid_o, mem_rw_o, mem_addr_o, mem_wdata_o,
    input  mem_ready_i, mem_rdata_i
  );

  modport master (
    output ic_req_valid_i, ic_req_addr_i,
    input  ic_ack_o, ic_rdata_o,
    output dc_req_valid_i, dc_req_rw_i, dc_req_addr_i, dc_req_wdata_i,
    input  dc_ack_o, dc_rdata_o,
    input  mem_valid_o, mem_rw_o, mem_addr_o, mem_wdata_o,
    output mem_ready_i, mem_rdata_i
  );

endinterface

// File: rtl/mem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module mem_arbiter_sat_counter #(
  parameter int unsigned Max   = 4,
  parameter int unsigned Width = $clog2(Max + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Next count: clear, else step up unless already at Max.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != Width'(Max))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Serialises icache/dcache line transactions onto one memory port. The dcache
// wins ties until the icache has watched STARVE_MAX dcache grants go by.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = mem_arbiter_pkg::ADDR_W,
  parameter int unsigned LINE_W     = mem_arbiter_pkg::LINE_W,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  mem_arbiter_if.slave bus,
  output logic [31:0]  no_ic_grant_o,
  output logic [31:0]  no_dc_grant_o,
  output logic [31:0]  no_conflict_o
);

  import mem_arbiter_pkg::*;

  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);

  arb_state_e        state_q, state_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              ic_ack_q, ic_ack_d;
  logic              dc_ack_q, dc_ack_d;
  logic [LINE_W-1:0] ic_rdata_q, ic_rdata_d;
  logic [LINE_W-1:0] dc_rdata_q, dc_rdata_d;
  logic [31:0]       ic_cnt_q, ic_cnt_d;
  logic [31:0]       dc_cnt_q, dc_cnt_d;
  logic [31:0]       cf_cnt_q, cf_cnt_d;

  logic               in_idle;
  logic               starve_full;
  logic               grant_d;
  logic               grant_i;
  logic               starve_inc;
  logic               starve_clr;
  logic [StarveW-1:0] starve_cnt;

  // Grant decision; only meaningful in IDLE, the two grants are exclusive.
  always_comb begin
    in_idle     = (state_q == ArbIdle);
    starve_full = (starve_cnt == StarveW'(STARVE_MAX));
    grant_d     = in_idle && bus.dc_req_valid_i && (!bus.ic_req_valid_i || !starve_full);
    grant_i     = in_idle && bus.ic_req_valid_i && (!bus.dc_req_valid_i || starve_full);
    starve_inc  = grant_d && bus.ic_req_valid_i;
    // Idle with no icache request also clears, which covers a dcache-only grant.
    starve_clr  = grant_i || (in_idle && !bus.ic_req_valid_i);
  end

  mem_arbiter_sat_counter #(
    .Max   (STARVE_MAX),
    .Width (StarveW)
  ) u_starve_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (starve_clr),
    .inc_i (starve_inc),
    .cnt_o (starve_cnt)
  );

  // FSM next state, memory request registers, acks, rdata and statistics.
  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ic_ack_d    = 1'b0;
    dc_ack_d    = 1'b0;
    ic_rdata_d  = ic_rdata_q;
    dc_rdata_d  = dc_rdata_q;
    ic_cnt_d    = ic_cnt_q;
    dc_cnt_d    = dc_cnt_q;
    cf_cnt_d    = cf_cnt_q;

    if (in_idle && bus.ic_req_valid_i && bus.dc_req_valid_i) begin
      cf_cnt_d = cf_cnt_q + 32'd1;
    end

    case (state_q)
      ArbIdle: begin
        if (grant_d) begin
          state_d     = ArbBusyD;
          mem_valid_d = 1'b1;
          mem_rw_d    = bus.dc_req_rw_i;
          mem_addr_d  = bus.dc_req_addr_i;
          mem_wdata_d = bus.dc_req_wdata_i;
          dc_cnt_d    = dc_cnt_q + 32'd1;
        end else if (grant_i) begin
          state_d     = ArbBusyI;
          mem_valid_d = 1'b1;
          mem_rw_d    = 1'b0;
          mem_addr_d  = bus.ic_req_addr_i;
          mem_wdata_d = '0;
          ic_cnt_d    = ic_cnt_q + 32'd1;
        end
      end
      ArbBusyI: begin
        if (bus.mem_ready_i) begin
          state_d     = ArbAck;
          mem_valid_d = 1'b0;
          ic_rdata_d  = bus.mem_rdata_i;
          ic_ack_d    = 1'b1;
        end
      end
      ArbBusyD: begin
        if (bus.mem_ready_i) begin
          state_d     = ArbAck;
          mem_valid_d = 1'b0;
          dc_rdata_d  = bus.mem_rdata_i;
          dc_ack_d    = 1'b1;
        end
      end
      ArbAck: begin
        state_d = ArbIdle;
      end
      default: begin
        state_d = ArbIdle;
      end
    endcase
  end

  // All state in one register bank; reset abandons any in-flight transaction.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ArbIdle;
      mem_valid_q <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ic_ack_q    <= 1'b0;
      dc_ack_q    <= 1'b0;
      ic_rdata_q  <= '0;
      dc_rdata_q  <= '0;
      ic_cnt_q    <= '0;
      dc_cnt_q    <= '0;
      cf_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ic_ack_q    <= ic_ack_d;
      dc_ack_q    <= dc_ack_d;
      ic_rdata_q  <= ic_rdata_d;
      dc_rdata_q  <= dc_rdata_d;
      ic_cnt_q    <= ic_cnt_d;
      dc_cnt_q    <= dc_cnt_d;
      cf_cnt_q    <= cf_cnt_d;
    end
  end

  assign bus.mem_valid_o = mem_valid_q;
  assign bus.mem_rw_o    = mem_rw_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.ic_ack_o    = ic_ack_q;
  assign bus.dc_ack_o    = dc_ack_q;
  assign bus.ic_rdata_o  = ic_rdata_q;
  assign bus.dc_rdata_o  = dc_rdata_q;
  assign no_ic_grant_o   = ic_cnt_q;
  assign no_dc_grant_o   = dc_cnt_q;
  assign no_conflict_o   = cf_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and random stimulus for mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned STARVE_MAX = 4;
  localparam int PhFree = 0;
  localparam int PhBusy = 1;
  localparam int PhAck  = 2;

  logic        clk_i;
  logic        rst_i;
  logic [31:0] no_ic_grant_o;
  logic [31:0] no_dc_grant_o;
  logic [31:0] no_conflict_o;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  mem_arbiter #(
    .ADDR_W     (ADDR_W),
    .LINE_W     (LINE_W),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .bus           (bus),
    .no_ic_grant_o (no_ic_grant_o),
    .no_dc_grant_o (no_dc_grant_o),
    .no_conflict_o (no_conflict_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  // Requesters, memory drive values and reset drive.
  line_req_t         ic_r, dc_r;
  logic              rdy;
  logic [LINE_W-1:0] rdat;
  logic              rst_drv;

  // Transaction-level model: phase of the current cycle, the granted request,
  // the starvation tally and the expected statistics.
  int                m_phase;
  bit                m_win_ic;
  bit                m_first;
  logic [ADDR_W-1:0] m_addr;
  logic              m_rw;
  logic [LINE_W-1:0] m_wdata;
  logic [LINE_W-1:0] m_rdata;
  int unsigned       m_starve;
  logic [31:0]       e_ic, e_dc, e_cf;
  string             dut_log;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs,
                     input logic [LINE_W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rnd_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic set_ic(input logic [ADDR_W-1:0] a);
    ic_r.valid = 1'b1;
    ic_r.addr  = a;
    ic_r.rw    = 1'b0;
    ic_r.wdata = '0;
  endtask

  task automatic set_dc(input logic [ADDR_W-1:0] a, input logic rw, input logic [LINE_W-1:0] d);
    dc_r.valid = 1'b1;
    dc_r.addr  = a;
    dc_r.rw    = rw;
    dc_r.wdata = d;
  endtask

  task automatic model_reset();
    m_phase  = PhFree;
    m_win_ic = 1'b0;
    m_first  = 1'b0;
    m_starve = 0;
    e_ic     = '0;
    e_dc     = '0;
    e_cf     = '0;
  endtask

  // One clock cycle: check the outputs of this cycle, drive inputs, advance model.
  task automatic step();
    chk("mem_valid", bus.mem_valid_o, (m_phase == PhBusy));
    if (m_phase == PhBusy) begin
      chk("mem_addr", bus.mem_addr_o, m_addr);
      chk("mem_rw", bus.mem_rw_o, m_rw);
      if (!m_win_ic) chk("mem_wdata", bus.mem_wdata_o, m_wdata);
      if (m_first) dut_log = {dut_log, (bus.mem_addr_o == ic_r.addr && ic_r.valid) ? "I" : "D"};
      m_first = 1'b0;
    end
    chk("ic_ack", bus.ic_ack_o, (m_phase == PhAck) && m_win_ic);
    chk("dc_ack", bus.dc_ack_o, (m_phase == PhAck) && !m_win_ic);
    if (m_phase == PhAck) begin
      if (m_win_ic) chk("ic_rdata", bus.ic_rdata_o, m_rdata);
      else          chk("dc_rdata", bus.dc_rdata_o, m_rdata);
      if (m_win_ic) ic_r.valid = 1'b0;
      else          dc_r.valid = 1'b0;
    end
    chk("no_ic_grant", no_ic_grant_o, e_ic);
    chk("no_dc_grant", no_dc_grant_o, e_dc);
    chk("no_conflict", no_conflict_o, e_cf);

    bus.ic_req_valid_i = ic_r.valid;
    bus.ic_req_addr_i  = ic_r.addr;
    bus.dc_req_valid_i = dc_r.valid;
    bus.dc_req_rw_i    = dc_r.rw;
    bus.dc_req_addr_i  = dc_r.addr;
    bus.dc_req_wdata_i = dc_r.wdata;
    bus.mem_ready_i    = rdy;
    bus.mem_rdata_i    = rdat;
    rst_i              = rst_drv;

    if (rst_drv) begin
      model_reset();
    end else if (m_phase == PhFree) begin
      if (ic_r.valid && dc_r.valid) e_cf++;
      if (dc_r.valid && (!ic_r.valid || m_starve < STARVE_MAX)) begin
        m_win_ic = 1'b0;
        m_addr   = dc_r.addr;
        m_rw     = dc_r.rw;
        m_wdata  = dc_r.wdata;
        e_dc++;
        if (!ic_r.valid)                m_starve = 0;
        else if (m_starve < STARVE_MAX) m_starve++;
        m_phase = PhBusy;
        m_first = 1'b1;
      end else if (ic_r.valid) begin
        m_win_ic = 1'b1;
        m_addr   = ic_r.addr;
        m_rw     = 1'b0;
        e_ic++;
        m_starve = 0;
        m_phase  = PhBusy;
        m_first  = 1'b1;
      end else begin
        m_starve = 0;
      end
    end else if (m_phase == PhBusy) begin
      if (rdy) begin
        m_rdata = rdat;
        m_phase = PhAck;
      end
    end else begin
      m_phase = PhFree;
    end
    rdy = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  // Wait (bounded) for a grant, hold memory for lat cycles, answer, and pass the ack cycle.
  task automatic serve(input int lat, input logic [LINE_W-1:0] d);
    int guard = 0;
    while (m_phase != PhBusy && guard < 20) begin
      step();
      guard++;
    end
    n_vec++;
    assert (m_phase == PhBusy) else begin
      n_err++;
      $error("FAIL grant_wait: no grant within %0d cycles, phase %0d", guard, m_phase);
    end
    repeat (lat) step();
    rdat = d;
    rdy  = 1'b1;
    step();
    step();
  endtask

  initial begin
    ic_r    = '0;
    dc_r    = '0;
    rdy     = 1'b0;
    rdat    = '0;
    rst_drv = 1'b0;
    dut_log = "";
    model_reset();
    rst_i              = 1'b1;
    bus.ic_req_valid_i = 1'b0;
    bus.ic_req_addr_i  = '0;
    bus.dc_req_valid_i = 1'b0;
    bus.dc_req_rw_i    = 1'b0;
    bus.dc_req_addr_i  = '0;
    bus.dc_req_wdata_i = '0;
    bus.mem_ready_i    = 1'b0;
    bus.mem_rdata_i    = '0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Reset state.
    chk("rst_ic_rdata", bus.ic_rdata_o, '0);
    chk("rst_dc_rdata", bus.dc_rdata_o, '0);
    chk("rst_mem_addr", bus.mem_addr_o, '0);

    // Single icache refill, memory ready after 2 cycles.
    set_ic(32'h100);
    serve(2, {16{8'hA5}});
    chk("ic_grants_1", no_ic_grant_o, 32'd1);

    // Dcache write-back, held for 3 cycles.
    set_dc(32'h2000, 1'b1, 128'h1234);
    serve(3, rnd_line());
    chk("dc_grants_1", no_dc_grant_o, 32'd1);

    // Simultaneous requests: dcache first, then icache.
    dut_log = "";
    set_ic(32'h300);
    set_dc(32'h400, 1'b0, '0);
    serve(1, rnd_line());
    serve(0, rnd_line());
    n_vec++;
    assert (dut_log == "DI") else begin
      n_err++;
      $error("FAIL tie_order: observed %s, expected DI", dut_log);
    end
    chk("conflict_seen", (no_conflict_o >= 32'd1), 1'b1);

    // Starvation bound: D,D,D,D,I then D.
    dut_log = "";
    set_ic(32'h500);
    for (int i = 0; i < 6; i++) begin
      if (!dc_r.valid) set_dc(32'h1000 + 32'(i * 16), 1'(i % 2), rnd_line());
      serve(i % 3, rnd_line());
    end
    n_vec++;
    assert (dut_log == "DDDDID") else begin
      n_err++;
      $error("FAIL starve_order: observed %s, expected DDDDID", dut_log);
    end

    // Reset while BUSY_D, then a late memory ready.
    set_dc(32'h600, 1'b0, '0);
    step();
    step();
    rst_drv = 1'b1;
    step();
    rst_drv    = 1'b0;
    dc_r.valid = 1'b0;
    chk("rst_mid_ic_rdata", bus.ic_rdata_o, '0);
    chk("rst_mid_dc_rdata", bus.dc_rdata_o, '0);
    chk("rst_mid_mem_addr", bus.mem_addr_o, '0);
    chk("rst_mid_mem_rw", bus.mem_rw_o, '0);
    rdat = rnd_line();
    rdy  = 1'b1;
    step();
    step();
    step();

    // Memory ready while idle is ignored.
    rdat = rnd_line();
    rdy  = 1'b1;
    step();
    step();
    step();

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      if (!ic_r.valid && ($urandom() % 4 == 0)) set_ic($urandom() & 32'hFFFF_FFF0);
      if (!dc_r.valid && ($urandom() % 3 == 0))
        set_dc($urandom() & 32'hFFFF_FFF0, 1'($urandom() % 2), rnd_line());
      rdy  = ($urandom() % 3 == 0);
      rdat = rnd_line();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
